// File: rtl/cache_filler.sv
// cache_filler: memory-side responder for the cached bus controller.
// It accepts single READ/WRITE commands, acknowledges them with a one-cycle
// pulse, and owns a single four-halfword read line. Read misses become a
// 4-beat critical-word-first burst; writes become single-halfword writes
// with an optional write-through patch of the line.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cmd_req[1:0]      0/3 idle, 1 WRITE, 2 READ (level, held until cmd_ack)
//   cmd_ack           one-cycle command acknowledge
//   cache_invalid     clear the line (with READ or alone in idle)
//   cache_update      enable write-through patch (with WRITE)
//   addr[25:0]        byte address; wdata[15:0] write data
//   cache_addr[22:0]  line tag; cache_data_1d[63:0] line data;
//   cache_valid[3:0]  per-word valid bits
//   mem_req/mem_wr/mem_addr/mem_wdata  SDRAM controller request
//   mem_ack/mem_rvalid/mem_rdata       SDRAM controller response
module cache_filler (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd_req,
  output logic        cmd_ack,
  input  logic        cache_invalid,
  input  logic        cache_update,
  input  logic [25:0] addr,
  input  logic [15:0] wdata,
  output logic [22:0] cache_addr,
  output logic [63:0] cache_data_1d,
  output logic [3:0]  cache_valid,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned TAG_W   = 23;
  localparam int unsigned MADDR_W = 25;
  localparam int unsigned HW_W    = 16;
  localparam int unsigned LINE_W  = 64;
  localparam int unsigned WORDS   = 4;

  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RDATA = 2'd1,
    S_WREQ  = 2'd2,
    S_WDONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 cmd_ack_q, cmd_ack_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [MADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [HW_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [TAG_W-1:0]     cache_addr_q, cache_addr_d;
  logic [LINE_W-1:0]    cache_data_q, cache_data_d;
  logic [WORDS-1:0]     cache_valid_q, cache_valid_d;
  logic [1:0]           start_q, start_d;
  logic [1:0]           beat_q, beat_d;
  logic [1:0]           word_idx;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cmd_ack_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cache_addr_q  <= {TAG_W{1'b1}};
      cache_data_q  <= '0;
      cache_valid_q <= '0;
      start_q       <= '0;
      beat_q        <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ack_q     <= cmd_ack_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
      cache_valid_q <= cache_valid_d;
      start_q       <= start_d;
      beat_q        <= beat_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d       = state_q;
    cmd_ack_d     = 1'b0;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    cache_valid_d = cache_valid_q;
    start_d       = start_q;
    beat_d        = beat_q;
    word_idx      = addr[2:1];

    case (state_q)
      S_IDLE: begin
        if (cmd_req == CMD_READ) begin
          // Acknowledge immediately; the line is refilled in the background
          cmd_ack_d     = 1'b1;
          cache_addr_d  = addr[25:3];
          cache_valid_d = '0;
          start_d       = addr[2:1];
          beat_d        = '0;
          mem_req_d     = 1'b1;
          mem_wr_d      = 1'b0;
          mem_addr_d    = addr[25:1];
          state_d       = S_RDATA;
        end else begin
          if (cmd_req == CMD_WRITE) begin
            mem_req_d   = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = addr[25:1];
            mem_wdata_d = wdata;
            // Write-through only into a word that already holds valid data
            if (cache_update && (addr[25:3] == cache_addr_q) &&
                cache_valid_q[word_idx]) begin
              cache_data_d[{word_idx, 4'b0000} +: HW_W] = wdata;
            end
            state_d = S_WREQ;
          end
          if (cache_invalid) begin
            cache_valid_d = '0;
          end
        end
      end

      S_RDATA: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
        end
        if (mem_rvalid) begin
          // Critical word first: beat k lands in word (start + k) mod 4
          word_idx                                   = start_q + beat_q;
          cache_data_d[{word_idx, 4'b0000} +: HW_W]  = mem_rdata;
          cache_valid_d[word_idx]                    = 1'b1;
          beat_d                                     = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = S_IDLE;
          end
        end
      end

      S_WREQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cmd_ack_d = 1'b1;
          state_d   = S_WDONE;
        end
      end

      // Guard cycle: the bus withdraws cmd_req before the next sample
      S_WDONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ack       = cmd_ack_q;
  assign mem_req       = mem_req_q;
  assign mem_wr        = mem_wr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cache_addr    = cache_addr_q;
  assign cache_data_1d = cache_data_q;
  assign cache_valid   = cache_valid_q;

endmodule

// File: tb/tb_cache_filler.sv
// Directed bench for cache_filler: read burst fill, write hit/miss,
// stale READ, delayed mem_ack, idle invalidate and mid-burst reset.
module tb_cache_filler;

  logic        clk;
  logic        reset;
  logic [1:0]  cmd_req;
  logic        cmd_ack;
  logic        cache_invalid;
  logic        cache_update;
  logic [25:0] addr;
  logic [15:0] wdata;
  logic [22:0] cache_addr;
  logic [63:0] cache_data_1d;
  logic [3:0]  cache_valid;
  logic        mem_req;
  logic        mem_wr;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  int n_cmp;
  int n_bad;
  int n_ack;

  cache_filler dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_req       (cmd_req),
    .cmd_ack       (cmd_ack),
    .cache_invalid (cache_invalid),
    .cache_update  (cache_update),
    .addr          (addr),
    .wdata         (wdata),
    .cache_addr    (cache_addr),
    .cache_data_1d (cache_data_1d),
    .cache_valid   (cache_valid),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cmd_ack"},     64'(cmd_ack),       64'h0);
    chk({tag, " mem_req"},     64'(mem_req),       64'h0);
    chk({tag, " mem_wr"},      64'(mem_wr),        64'h0);
    chk({tag, " mem_addr"},    64'(mem_addr),      64'h0);
    chk({tag, " mem_wdata"},   64'(mem_wdata),     64'h0);
    chk({tag, " cache_addr"},  64'(cache_addr),    64'h7FFFFF);
    chk({tag, " cache_data"},  cache_data_1d,      64'h0);
    chk({tag, " cache_valid"}, 64'(cache_valid),   64'h0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_ack = 0;
    reset = 1'b0; cmd_req = 2'd0; cache_invalid = 1'b0; cache_update = 1'b0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b1;
    tick();

    // READ addr 0x0001234: tag 0x246, critical word 2, mem_addr 0x91A
    cmd_req = 2'd2; addr = 26'h0001234;
    tick();
    chk("rd ack",        64'(cmd_ack),     64'h1);
    chk("rd mem_req",    64'(mem_req),     64'h1);
    chk("rd mem_wr",     64'(mem_wr),      64'h0);
    chk("rd mem_addr",   64'(mem_addr),    64'h091A);
    chk("rd cache_addr", 64'(cache_addr),  64'h246);
    chk("rd valid0",     64'(cache_valid), 64'h0);
    // Stale READ still held during the ack cycle; memory accepts now
    mem_ack = 1'b1;
    tick();
    chk("rd stale noack", 64'(cmd_ack), 64'h0);
    chk("rd req drop",    64'(mem_req), 64'h0);
    cmd_req = 2'd0; mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
    tick();
    chk("beat0 valid", 64'(cache_valid), 64'h4);
    chk("beat0 data",  cache_data_1d,    64'h0000_AAAA_0000_0000);
    chk("beat0 noack", 64'(cmd_ack),     64'h0);
    mem_rdata = 16'hBBBB;
    tick();
    chk("beat1 valid", 64'(cache_valid), 64'hC);
    mem_rdata = 16'hCCCC;
    tick();
    chk("beat2 valid", 64'(cache_valid), 64'hD);
    mem_rdata = 16'hDDDD;
    tick();
    chk("beat3 valid", 64'(cache_valid), 64'hF);
    chk("beat3 data",  cache_data_1d,    64'hBBBB_AAAA_DDDD_CCCC);
    chk("beat3 noack", 64'(cmd_ack),     64'h0);
    // Stray beat outside the burst is ignored
    mem_rdata = 16'h5555;
    tick();
    chk("stray data",  cache_data_1d,    64'hBBBB_AAAA_DDDD_CCCC);
    chk("stray valid", 64'(cache_valid), 64'hF);
    chk("one burst req", 64'(mem_req),   64'h0);
    mem_rvalid = 1'b0;

    // WRITE hit: addr 0x0001232 -> tag 0x246 word 1, mem_addr 0x919; mem_ack delayed
    cmd_req = 2'd1; addr = 26'h0001232; wdata = 16'hBEEF; cache_update = 1'b1;
    tick();
    cache_update = 1'b0;
    chk("wh data",      cache_data_1d,    64'hBBBB_AAAA_BEEF_CCCC);
    chk("wh valid",     64'(cache_valid), 64'hF);
    chk("wh mem_req",   64'(mem_req),     64'h1);
    chk("wh mem_wr",    64'(mem_wr),      64'h1);
    chk("wh mem_addr",  64'(mem_addr),    64'h0919);
    chk("wh mem_wdata", 64'(mem_wdata),   64'hBEEF);
    chk("wh noack",     64'(cmd_ack),     64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cmd_ack) n_ack++;
      chk("wh req held", 64'(mem_req), 64'h1);
    end
    chk("wh no early ack", 64'(n_ack), 64'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wh ack",      64'(cmd_ack), 64'h1);
    chk("wh req drop", 64'(mem_req), 64'h0);
    // cmd_req still held in the ack cycle: guard state must ignore it
    tick();
    chk("wh guard ack", 64'(cmd_ack), 64'h0);
    chk("wh guard req", 64'(mem_req), 64'h0);
    cmd_req = 2'd0;
    tick();

    // WRITE miss: tag 0x400 differs, cache untouched, write still issued
    cmd_req = 2'd1; addr = 26'h0002000; wdata = 16'h1111; cache_update = 1'b1;
    tick();
    cache_update = 1'b0;
    chk("wm data",      cache_data_1d,    64'hBBBB_AAAA_BEEF_CCCC);
    chk("wm tag",       64'(cache_addr),  64'h246);
    chk("wm mem_addr",  64'(mem_addr),    64'h1000);
    chk("wm mem_wdata", 64'(mem_wdata),   64'h1111);
    chk("wm mem_req",   64'(mem_req),     64'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wm ack", 64'(cmd_ack), 64'h1);
    cmd_req = 2'd0;
    tick();
    tick();

    // Invalidate alone in idle
    cache_invalid = 1'b1;
    tick();
    cache_invalid = 1'b0;
    chk("inv valid", 64'(cache_valid), 64'h0);
    chk("inv data",  cache_data_1d,    64'hBBBB_AAAA_BEEF_CCCC);

    // READ addr 0x0000006: word 3, then reset after two beats
    cmd_req = 2'd2; addr = 26'h0000006;
    tick();
    chk("r2 ack",      64'(cmd_ack),  64'h1);
    chk("r2 mem_addr", 64'(mem_addr), 64'h3);
    cmd_req = 2'd0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_rdata = 16'h5678;
    tick();
    chk("r2 valid", 64'(cache_valid), 64'h9);
    reset = 1'b0;
    #2;
    chk_reset_vals("midrst");
    #2;
    reset = 1'b1;
    mem_rdata = 16'h9ABC;
    tick();
    mem_rdata = 16'hDEF0;
    tick();
    mem_rvalid = 1'b0;
    chk("post rst valid", 64'(cache_valid), 64'h0);
    chk("post rst data",  cache_data_1d,    64'h0);
    chk("post rst req",   64'(mem_req),     64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
